// File: rtl/q2s_vec_seq.sv
// Exhaustive stimulus generator and response checker for the q2s combinational block.
// Walks {a,b,c,d} through 0..15, holds each vector, samples f/g and scores them against truth tables.
module q2s_vec_seq #(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXP_F       = 16'h0000,
  parameter logic [15:0] EXP_G       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f,
  input  logic        g,
  output logic        busy,
  output logic        done,
  output logic [3:0]  vec_idx,
  output logic [15:0] f_log,
  output logic [15:0] g_log,
  output logic [4:0]  err_cnt,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISHED} state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       miss;

  // f and g are combinational from the registered a..d, so they already reflect vec_idx here.
  assign miss = (f != EXP_F[vec_idx]) || (g != EXP_G[vec_idx]);

  // NOTE: every register below is written with <= so all updates on an edge see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      {a, b, c, d} <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vec_idx      <= '0;
      f_log        <= '0;
      g_log        <= '0;
      err_cnt      <= '0;
      mismatch     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            state        <= DRIVE;
            vec_idx      <= '0;
            {a, b, c, d} <= 4'd0;
            cnt          <= '0;
            f_log        <= '0;
            g_log        <= '0;
            err_cnt      <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == LAST_CNT) begin
            f_log[vec_idx] <= f;
            g_log[vec_idx] <= g;
            if (miss) begin
              err_cnt  <= err_cnt + 5'd1;
              mismatch <= 1'b1;
            end
            cnt <= '0;
            if (vec_idx == 4'd15) begin
              state        <= FINISHED;
              busy         <= 1'b0;
              done         <= 1'b1;
              vec_idx      <= '0;
              {a, b, c, d} <= 4'd0;
            end else begin
              vec_idx      <= vec_idx + 4'd1;
              {a, b, c, d} <= vec_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q2s_vec_seq.sv
// Directed bench for q2s_vec_seq with a behavioural q2s model (f = parity, g = a&b) and optional fault on vector 13.
module tb_q2s_vec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        a, b, c, d;
  logic        f, g;
  logic        busy, done, mismatch;
  logic [3:0]  vec_idx;
  logic [15:0] f_log, g_log;
  logic [4:0]  err_cnt;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign f = a ^ b ^ c ^ d;
  assign g = a & b & ~(fault && ({a, b, c, d} == 4'd13));

  q2s_vec_seq #(
    .HOLD_CYCLES(2),
    .EXP_F      (16'h6996),
    .EXP_G      (16'hF000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .f       (f),
    .g       (g),
    .busy    (busy),
    .done    (done),
    .vec_idx (vec_idx),
    .f_log   (f_log),
    .g_log   (g_log),
    .err_cnt (err_cnt),
    .mismatch(mismatch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " abcd"}, 32'({a, b, c, d}), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " vec_idx"}, 32'(vec_idx), 32'd0);
    check({tag, " f_log"}, 32'(f_log), 32'd0);
    check({tag, " g_log"}, 32'(g_log), 32'd0);
    check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, " mismatch"}, 32'(mismatch), 32'd0);
  endtask

  // One full run: start pulse, per-edge checks over 32 clocks, end-of-run readout.
  task automatic run(input bit inject, input bit poke);
    int mm_seen;
    logic exp_mm;
    fault   = inject;
    mm_seen = 0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("start f_log clear", 32'(f_log), 32'd0);
    check("start g_log clear", 32'(g_log), 32'd0);
    check("start err_cnt clear", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 32; k++) begin
      check("run abcd", 32'({a, b, c, d}), 32'(k / 2));
      check("run vec_idx", 32'(vec_idx), 32'(k / 2));
      check("run busy", 32'(busy), 32'd1);
      check("run done", 32'(done), 32'd0);
      exp_mm = inject && (k == 28);
      check("run mismatch", 32'(mismatch), 32'(exp_mm));
      if (mismatch) mm_seen++;
      start = poke && (k == 6 || k == 18);
      tick();
    end
    start = 1'b0;
    check("end done", 32'(done), 32'd1);
    check("end busy", 32'(busy), 32'd0);
    check("end abcd", 32'({a, b, c, d}), 32'd0);
    check("end vec_idx", 32'(vec_idx), 32'd0);
    check("end mismatch", 32'(mismatch), 32'd0);
    check("end f_log", 32'(f_log), 32'h6996);
    check("end g_log", 32'(g_log), inject ? 32'hD000 : 32'hF000);
    check("end err_cnt", 32'(err_cnt), inject ? 32'd1 : 32'd0);
    check("mismatch pulses", 32'(mm_seen), inject ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fault = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_all_zero("idle");

    run(1'b0, 1'b0);

    for (int i = 0; i < 3; i++) tick();
    check("done hold", 32'(done), 32'd1);
    check("done hold f_log", 32'(f_log), 32'h6996);

    run(1'b1, 1'b0);
    tick();
    check("done hold err_cnt", 32'(err_cnt), 32'd1);

    // Restart from DONE with stray start pulses during the run.
    run(1'b0, 1'b1);

    // Reset mid-run while vector 7 is driven.
    fault = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("pre-reset vec_idx", 32'(vec_idx), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid-run reset");
    for (int i = 0; i < 5; i++) tick();
    check_all_zero("after reset idle");

    run(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q2s_vec_seq.md
Name: q2s_vec_seq

Overview:
- Self-checking stimulus and response stage for the q2s combinational block. It is the stage directly upstream and downstream of q2s.
- Drives q2s inputs a,b,c,d through all 16 combinations in ascending order (a = MSB). Each vector is held for a programmable number of clocks.
- At the end of each hold it samples q2s outputs f,g, logs them per vector, and compares them against expected truth tables.
- Replaces the hand-written exhaustive initial-block stimulus with synthesisable, on-board-checkable logic.

Parameters:
- HOLD_CYCLES, 20, clocks each vector is held before sampling; legal range 1..255.
- EXP_F, 16'h0000, expected f per vector; bit i is the expected value for vector i = {a,b,c,d}.
- EXP_G, 16'h0000, expected g per vector; same bit indexing as EXP_F.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a run; sampled in IDLE and DONE only.
- a  output  1  stimulus bit 3 (MSB of vector index).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0.
- f  input  1  q2s output f, combinational from a..d.
- g  input  1  q2s output g, combinational from a..d.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or rst.
- vec_idx  output  4  index of the vector currently driven.
- f_log  output  16  captured f; bit i corresponds to vector i.
- g_log  output  16  captured g; bit i corresponds to vector i.
- err_cnt  output  5  number of vectors with f or g mismatching (0..16).
- mismatch  output  1  one-cycle pulse on a sample edge that detects a mismatch.

Behaviour:
- Reset: every output is 0 (a,b,c,d, busy, done, vec_idx, f_log, g_log, err_cnt, mismatch). State = IDLE; hold counter = 0. rst is synchronous and takes priority over every other event, including mid-run; a run interrupted by rst is abandoned, not resumed.
- The stimulus outputs are registered: {a,b,c,d} == vec_idx at all times while busy.
- States:
  - IDLE: outputs static. start=1 -> DRIVE. On that edge: vec_idx<=0, cnt<=0, f_log/g_log/err_cnt<=0, busy<=1.
  - DRIVE: cnt increments each clock. When cnt == HOLD_CYCLES-1, that edge samples f,g:
    - f_log[vec_idx]<=f and g_log[vec_idx]<=g.
    - If (f != EXP_F[vec_idx]) or (g != EXP_G[vec_idx]): err_cnt<=err_cnt+1 and mismatch<=1 for one cycle.
    - Then if vec_idx == 15 -> DONE, busy<=0, done<=1, {a,b,c,d}<=0000, vec_idx<=0. Otherwise vec_idx<=vec_idx+1 and cnt<=0.
  - DONE: done held at 1; logs and err_cnt held for readout. start=1 -> DRIVE with the same initialisation as from IDLE, and done<=0 on that edge.
- Timing:
  - Vector i is driven from edge S+i*HOLD_CYCLES through edge S+(i+1)*HOLD_CYCLES, where S is the start-accept edge.
  - Vector i is sampled on edge S+(i+1)*HOLD_CYCLES.
  - done rises on edge S+16*HOLD_CYCLES.
  - With HOLD_CYCLES=1 every clock samples, and f,g settle combinationally within the cycle.
- start while busy is ignored; the run is not restarted or extended. A start that remains high continuously is acted on only in IDLE or DONE.
- A double mismatch (f and g both wrong) on one vector counts once.
- err_cnt cannot exceed 16; no saturation logic is needed beyond 5-bit width.
- mismatch is 0 on every non-sample edge and in IDLE/DONE.

Test Plan:
- Reset then idle: rst high 2 cycles, start=0 for 10 cycles -> all outputs 0, busy=0, done=0.
- Clean run: HOLD_CYCLES=2, bench model f=a^b^c^d, g=a&b. EXP_F=16'h6996, EXP_G=16'hF000. Pulse start -> vector i visible on a..d for 2 clocks each; done rises 32 clocks after the start edge. Required: f_log=6996, g_log=F000, err_cnt=0, mismatch never pulses.
- Fault injection: same setup, but model forces g=0 for vector 13 -> mismatch pulses exactly once, on vector 13's sample edge; err_cnt=1; g_log=D000.
- Start while busy: extra start pulses at vectors 3 and 9 -> sequence is uninterrupted; done still occurs 32 clocks after the original start.
- Reset mid-run: assert rst at vector 7 -> next edge all outputs 0 and IDLE. A new start produces a full clean run with err_cnt=0.
- Restart from DONE: after a run with err_cnt=1, pulse start -> done drops and logs/err_cnt clear on the same edge; the second clean run ends with err_cnt=0.
